// File: rtl/stage_cfg_ctrl_pkg.sv
// stage_cfg_pkg: shared FSM states, command op bit positions and response
// status codes for the match-action stage configuration controller.
package stage_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT,
        WR_KEY,
        WR_ACT,
        RESP
    } state_t;

    // cmd_op bit meanings
    localparam int unsigned OP_KEY_BIT = 0;
    localparam int unsigned OP_ACT_BIT = 1;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_BAD_STAGE = 2'd1,
        ST_BAD_OP    = 2'd2,
        ST_TIMEOUT   = 2'd3
    } status_t;

endpackage

// File: rtl/stage_cfg_ctrl_if.sv
// stage_cfg_ctrl_if: command, response, stage-busy and broadcast config
// channel bundle. slave = controller side, master = host/stage side.
interface stage_cfg_ctrl_if
    import stage_cfg_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned KEY_LEN    = 896,
    parameter int unsigned ACT_LEN    = 25,
    parameter int unsigned ADDR_W     = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [2:0]            cmd_stage;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [KEY_LEN-1:0]    cmd_key;
    logic [KEY_LEN-1:0]    cmd_mask;
    logic [ACT_LEN-1:0]    cmd_action;
    logic [NUM_STAGES-1:0] stage_busy;
    logic [KEY_LEN-1:0]    cfg_key;
    logic [KEY_LEN-1:0]    cfg_mask;
    logic [ACT_LEN-1:0]    cfg_action;
    logic [ADDR_W-1:0]     cfg_addr;
    logic [NUM_STAGES-1:0] key_wr_en;
    logic [NUM_STAGES-1:0] act_wr_en;
    logic                  rsp_valid;
    logic                  rsp_ready;
    status_t               rsp_status;
    logic [15:0]           cfg_write_cnt;

    modport slave (
        input  cmd_valid, cmd_op, cmd_stage, cmd_addr, cmd_key, cmd_mask,
               cmd_action, stage_busy, rsp_ready,
        output cmd_ready, cfg_key, cfg_mask, cfg_action, cfg_addr,
               key_wr_en, act_wr_en, rsp_valid, rsp_status, cfg_write_cnt
    );

    modport master (
        output cmd_valid, cmd_op, cmd_stage, cmd_addr, cmd_key, cmd_mask,
               cmd_action, stage_busy, rsp_ready,
        input  cmd_ready, cfg_key, cfg_mask, cfg_action, cfg_addr,
               key_wr_en, act_wr_en, rsp_valid, rsp_status, cfg_write_cnt
    );

endinterface

// File: rtl/stage_cfg_ctrl.sv
// stage_cfg_ctrl: accepts one table-write command at a time, validates it,
// waits for the target stage to drain, pulses the per-stage key/action
// write strobes and returns a status response. All outputs are registered.
// Optional feature: define STAGE_CFG_TIMEOUT_EN to abort the busy-wait
// after TIMEOUT_CYC cycles with status 3.
module stage_cfg_ctrl
    import stage_cfg_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 5,
    parameter int unsigned KEY_LEN     = 896,
    parameter int unsigned ACT_LEN     = 25,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic             axis_clk,
    input logic             aresetn,
    stage_cfg_ctrl_if.slave cfg_if
);

    state_t                state, state_nxt;
    status_t               status_nxt;

    logic [1:0]            op_q;
    logic [2:0]            stage_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [KEY_LEN-1:0]    key_q;
    logic [KEY_LEN-1:0]    mask_q;
    logic [ACT_LEN-1:0]    action_q;

    logic [NUM_STAGES-1:0] stage_oh;
    logic                  busy_sel;
    logic                  accept;

    assign stage_oh = NUM_STAGES'(1) << stage_q;
    assign busy_sel = |(cfg_if.stage_busy & stage_oh);
    assign accept   = (state == IDLE) && cfg_if.cmd_valid && cfg_if.cmd_ready;

`ifdef STAGE_CFG_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            timeout;

    assign timeout = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

    // busy-wait cycle counter, cleared on every pass through CHECK
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wait_cnt <= '0;
        end else if (state == CHECK) begin
            wait_cnt <= '0;
        end else if (state == WAIT && busy_sel) begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end
`endif

    // state register
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state decode and the status to report on entry to RESP
    always_comb begin
        state_nxt  = state;
        status_nxt = ST_OK;
        case (state)
            IDLE:   if (accept) state_nxt = CHECK;
            CHECK: begin
                if (32'(stage_q) >= NUM_STAGES) begin
                    state_nxt  = RESP;
                    status_nxt = ST_BAD_STAGE;
                end else if (op_q == 2'b00) begin
                    state_nxt  = RESP;
                    status_nxt = ST_BAD_OP;
                end else begin
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                // stage going idle takes priority over an expiring timeout
                if (!busy_sel) begin
                    state_nxt = op_q[OP_KEY_BIT] ? WR_KEY : WR_ACT;
                end
`ifdef STAGE_CFG_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt  = RESP;
                    status_nxt = ST_TIMEOUT;
                end
`endif
            end
            WR_KEY: state_nxt = op_q[OP_ACT_BIT] ? WR_ACT : RESP;
            WR_ACT: state_nxt = RESP;
            RESP:   if (cfg_if.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // capture the command fields on the accepting handshake
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            op_q     <= '0;
            stage_q  <= '0;
            addr_q   <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            action_q <= '0;
        end else if (accept) begin
            op_q     <= cfg_if.cmd_op;
            stage_q  <= cfg_if.cmd_stage;
            addr_q   <= cfg_if.cmd_addr;
            key_q    <= cfg_if.cmd_key;
            mask_q   <= cfg_if.cmd_mask;
            action_q <= cfg_if.cmd_action;
        end
    end

    // registered outputs, decoded from the state being entered
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_if.cmd_ready     <= 1'b0;
            cfg_if.key_wr_en     <= '0;
            cfg_if.act_wr_en     <= '0;
            cfg_if.rsp_valid     <= 1'b0;
            cfg_if.rsp_status    <= ST_OK;
            cfg_if.cfg_key       <= '0;
            cfg_if.cfg_mask      <= '0;
            cfg_if.cfg_action    <= '0;
            cfg_if.cfg_addr      <= '0;
            cfg_if.cfg_write_cnt <= '0;
        end else begin
            cfg_if.cmd_ready <= (state_nxt == IDLE);
            cfg_if.key_wr_en <= (state_nxt == WR_KEY) ? stage_oh : '0;
            cfg_if.act_wr_en <= (state_nxt == WR_ACT) ? stage_oh : '0;
            cfg_if.rsp_valid <= (state_nxt == RESP);
            if (state != RESP && state_nxt == RESP) begin
                cfg_if.rsp_status <= status_nxt;
            end
            if (state_nxt == WR_KEY) begin
                cfg_if.cfg_key  <= key_q;
                cfg_if.cfg_mask <= mask_q;
                cfg_if.cfg_addr <= addr_q;
            end
            if (state_nxt == WR_ACT) begin
                cfg_if.cfg_action <= action_q;
                cfg_if.cfg_addr   <= addr_q;
            end
            if (state == RESP && cfg_if.rsp_ready && cfg_if.rsp_status == ST_OK &&
                cfg_if.cfg_write_cnt != '1) begin
                cfg_if.cfg_write_cnt <= cfg_if.cfg_write_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stage_cfg_ctrl.sv
// tb_stage_cfg_ctrl: table-driven directed commands, reset-during-WAIT and
// long busy-wait sequences, then randomized commands checked against a
// cycle-offset reference model of the command flow.
module tb_stage_cfg_ctrl;

    localparam int unsigned NS = 5;
    localparam int unsigned KL = 896;
    localparam int unsigned AL = 25;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 1024;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    stage_cfg_ctrl_if #(.NUM_STAGES(NS), .KEY_LEN(KL), .ACT_LEN(AL), .ADDR_W(AW)) cfg_if ();

    stage_cfg_ctrl #(
        .NUM_STAGES(NS), .KEY_LEN(KL), .ACT_LEN(AL), .ADDR_W(AW), .TIMEOUT_CYC(TO)
    ) dut (
        .axis_clk(clk),
        .aresetn (aresetn),
        .cfg_if  (cfg_if)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] stage;
        logic [3:0] addr;
        int         d;      // busy on target drops after this many edges past accept (-1: never busy)
        int         hold;   // cycles rsp_ready is held low
        logic [1:0] st;     // expected status
        int         key_c;  // expected key strobe cycle (0: none)
        int         act_c;  // expected action strobe cycle (0: none)
        int         rsp_c;  // expected first rsp_valid cycle
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [15:0]   m_cnt;
    logic [KL-1:0] m_key, m_mask;
    logic [AL-1:0] m_act;
    logic [AW-1:0] m_addr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [KL-1:0] got, input logic [KL-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            for (int w = 0; w < int'(KL / 64); w++) begin
                if (got[w*64 +: 64] !== exp[w*64 +: 64]) begin
                    $display("FAIL %s word %0d: got %0h expected %0h", name, w,
                             got[w*64 +: 64], exp[w*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [KL-1:0] rnd_key();
        logic [KL-1:0] v;
        for (int i = 0; i < int'(KL / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference timing from the command-flow rules: accept is cycle 0, check
    // at 1, wait decides from cycle 2 onwards, each write takes one cycle.
    task automatic model_exp(input logic [1:0] op, input logic [2:0] stage, input int d,
                             output logic [1:0] st, output int key_c, output int act_c,
                             output int rsp_c);
        int leave;
        key_c = 0;
        act_c = 0;
        if (int'(stage) >= int'(NS)) begin
            st = 2'd1; rsp_c = 2;
        end else if (op == 2'd0) begin
            st = 2'd2; rsp_c = 2;
        end else begin
            st = 2'd0;
            leave = (d + 1 > 2) ? d + 1 : 2;
            if (op[0]) key_c = leave + 1;
            if (op[1]) act_c = leave + 1 + int'(op[0]);
            rsp_c = leave + 1 + int'(op[0]) + int'(op[1]);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] stage,
                           input logic [AW-1:0] addr, input int d, input int hold,
                           input logic [NS-1:0] others, input logic [1:0] st,
                           input int key_c, input int act_c, input int rsp_c);
        logic [KL-1:0] k = rnd_key();
        logic [KL-1:0] m = rnd_key();
        logic [AL-1:0] a = AL'($urandom);
        logic [NS-1:0] oh = '0;
        logic [NS-1:0] exp_k, exp_a;
        int n = 0;
        int c;
        logic done = 1'b0;
        if (int'(stage) < int'(NS)) oh[stage] = 1'b1;

        while (!cfg_if.cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " cmd_ready_wait"}, 64'(cfg_if.cmd_ready), 64'd1);

        cfg_if.cmd_valid  = 1'b1;
        cfg_if.cmd_op     = op;
        cfg_if.cmd_stage  = stage;
        cfg_if.cmd_addr   = addr;
        cfg_if.cmd_key    = k;
        cfg_if.cmd_mask   = m;
        cfg_if.cmd_action = a;
        cfg_if.stage_busy = (others & ~oh) | ((d >= 0) ? oh : '0);
        @(posedge clk); #1;
        cfg_if.cmd_valid  = 1'b0;
        cfg_if.cmd_op     = 2'($urandom);
        cfg_if.cmd_stage  = 3'($urandom);
        cfg_if.cmd_addr   = AW'($urandom);
        cfg_if.cmd_key    = rnd_key();
        cfg_if.cmd_mask   = rnd_key();
        cfg_if.cmd_action = AL'($urandom);
        if (d == 0) cfg_if.stage_busy = cfg_if.stage_busy & ~oh;
        chk({tag, " cmd_ready_low"}, 64'(cfg_if.cmd_ready), 64'd0);

        for (int kk = 1; kk <= rsp_c + 5; kk++) begin
            @(posedge clk); #1;
            if (kk == d) cfg_if.stage_busy = cfg_if.stage_busy & ~oh;
            c = kk + 1;
            exp_k = (c == key_c) ? oh : '0;
            exp_a = (c == act_c) ? oh : '0;
            chk($sformatf("%s cyc%0d rsp/strobes", tag, c),
                64'({cfg_if.rsp_valid, cfg_if.key_wr_en, cfg_if.act_wr_en}),
                64'({(c == rsp_c), exp_k, exp_a}));
            if (c == key_c) begin
                chk_wide({tag, " cfg_key"}, cfg_if.cfg_key, k);
                chk_wide({tag, " cfg_mask"}, cfg_if.cfg_mask, m);
                chk({tag, " cfg_addr_key"}, 64'(cfg_if.cfg_addr), 64'(addr));
                m_key = k; m_mask = m; m_addr = addr;
            end
            if (c == act_c) begin
                chk({tag, " cfg_action"}, 64'(cfg_if.cfg_action), 64'(a));
                chk({tag, " cfg_addr_act"}, 64'(cfg_if.cfg_addr), 64'(addr));
                m_act = a; m_addr = addr;
            end
            if (c == rsp_c) begin
                chk({tag, " rsp_status"}, 64'(cfg_if.rsp_status), 64'(st));
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    chk($sformatf("%s hold%0d", tag, h),
                        64'({cfg_if.rsp_valid, cfg_if.rsp_status, cfg_if.key_wr_en, cfg_if.act_wr_en}),
                        64'({1'b1, st, NS'(0), NS'(0)}));
                end
                cfg_if.rsp_ready = 1'b1;
                @(posedge clk); #1;
                cfg_if.rsp_ready = 1'b0;
                if (st == 2'd0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                chk({tag, " after_rsp valid/ready"},
                    64'({cfg_if.rsp_valid, cfg_if.cmd_ready}), 64'({1'b0, 1'b1}));
                chk({tag, " cfg_write_cnt"}, 64'(cfg_if.cfg_write_cnt), 64'(m_cnt));
                chk_wide({tag, " cfg_key_hold"}, cfg_if.cfg_key, m_key);
                chk_wide({tag, " cfg_mask_hold"}, cfg_if.cfg_mask, m_mask);
                chk({tag, " cfg_action_hold"}, 64'(cfg_if.cfg_action), 64'(m_act));
                chk({tag, " cfg_addr_hold"}, 64'(cfg_if.cfg_addr), 64'(m_addr));
                done = 1'b1;
                break;
            end
        end
        chk({tag, " response_seen"}, 64'(done), 64'd1);
        cfg_if.stage_busy = '0;
    endtask

    vec_t tbl[10];

    initial begin
        logic [1:0] st;
        int key_c, act_c, rsp_c, d;
        logic [1:0] op;
        logic [2:0] stg;

        tbl[0] = '{2'd3, 3'd2, 4'd5,  -1, 0,  2'd0, 3,  4,  5};
        tbl[1] = '{2'd1, 3'd0, 4'd1,  -1, 1,  2'd0, 3,  0,  4};
        tbl[2] = '{2'd2, 3'd4, 4'd15, -1, 0,  2'd0, 0,  3,  4};
        tbl[3] = '{2'd3, 3'd6, 4'd3,  -1, 10, 2'd1, 0,  0,  2};
        tbl[4] = '{2'd0, 3'd1, 4'd2,  -1, 0,  2'd2, 0,  0,  2};
        tbl[5] = '{2'd2, 3'd0, 4'd9,  20, 10, 2'd0, 0,  22, 23};
        tbl[6] = '{2'd3, 3'd5, 4'd7,  -1, 0,  2'd1, 0,  0,  2};
        tbl[7] = '{2'd1, 3'd4, 4'd12, 1,  2,  2'd0, 3,  0,  4};
        tbl[8] = '{2'd3, 3'd1, 4'd0,  2,  0,  2'd0, 4,  5,  6};
        tbl[9] = '{2'd3, 3'd7, 4'd8,  -1, 3,  2'd1, 0,  0,  2};

        cfg_if.cmd_valid  = 1'b0;
        cfg_if.cmd_op     = '0;
        cfg_if.cmd_stage  = '0;
        cfg_if.cmd_addr   = '0;
        cfg_if.cmd_key    = '0;
        cfg_if.cmd_mask   = '0;
        cfg_if.cmd_action = '0;
        cfg_if.stage_busy = '0;
        cfg_if.rsp_ready  = 1'b0;
        m_cnt = '0; m_key = '0; m_mask = '0; m_act = '0; m_addr = '0;

        #12;
        chk("reset outputs",
            64'({cfg_if.cmd_ready, cfg_if.rsp_valid, cfg_if.rsp_status, cfg_if.key_wr_en,
                 cfg_if.act_wr_en, cfg_if.cfg_write_cnt}), 64'd0);
        chk_wide("reset cfg_key", cfg_if.cfg_key, '0);
        chk("reset cfg_action/addr", 64'({cfg_if.cfg_action, cfg_if.cfg_addr}), 64'd0);
        @(posedge clk); #2;
        aresetn = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready after reset", 64'(cfg_if.cmd_ready), 64'd1);

        foreach (tbl[i]) begin
            run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].stage, tbl[i].addr, tbl[i].d,
                    tbl[i].hold, '1, tbl[i].st, tbl[i].key_c, tbl[i].act_c, tbl[i].rsp_c);
        end

        // reset asserted while the command sits in WAIT
        cfg_if.cmd_valid  = 1'b1;
        cfg_if.cmd_op     = 2'd3;
        cfg_if.cmd_stage  = 3'd3;
        cfg_if.stage_busy = 5'b01000;
        @(posedge clk); #1;
        cfg_if.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        aresetn = 1'b0;
        #1;
        chk("async reset outputs",
            64'({cfg_if.cmd_ready, cfg_if.rsp_valid, cfg_if.key_wr_en, cfg_if.act_wr_en,
                 cfg_if.cfg_write_cnt}), 64'd0);
        chk_wide("async reset cfg_key", cfg_if.cfg_key, '0);
        m_cnt = '0; m_key = '0; m_mask = '0; m_act = '0; m_addr = '0;
        repeat (2) @(posedge clk);
        #2;
        aresetn = 1'b1;
        cfg_if.stage_busy = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post-reset idle %0d", i),
                64'({cfg_if.cmd_ready, cfg_if.rsp_valid, cfg_if.key_wr_en, cfg_if.act_wr_en}),
                64'({1'b1, 1'b0, NS'(0), NS'(0)}));
        end

        // target stage stuck busy well past the timeout limit
`ifdef STAGE_CFG_TIMEOUT_EN
        run_cmd("stuck_busy", 2'd1, 3'd4, 4'd6, 1200, 0, '0, 2'd3, 0, 0, int'(TO) + 2);
`else
        run_cmd("stuck_busy", 2'd1, 3'd4, 4'd6, 1200, 0, '0, 2'd0, 1202, 0, 1203);
`endif

        for (int r = 0; r < 60; r++) begin
            op  = 2'($urandom_range(0, 3));
            stg = 3'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 7)) - 1;
            model_exp(op, stg, d, st, key_c, act_c, rsp_c);
            run_cmd($sformatf("rnd%0d", r), op, stg, AW'($urandom), d,
                    int'($urandom_range(0, 3)), NS'($urandom), st, key_c, act_c, rsp_c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
